tag_lookup_ctrl: RTL and testbench

- Controller for a set-associative cache tag store. Owns WAYS instances of the dual-port tag_bank.
- Port A of every way is used for lookups, which return a 1-cycle hit/way result.
- Port B of every way is used for the post-reset clear sweep, line fills and address invalidations.
- Sits between the load/store address stage and the data-array/miss logic.

---
 rtl/tag_lookup_ctrl_pkg.sv | 10 +
 rtl/tag_bank.sv | 33 +++
 rtl/tag_lookup_ctrl_compare.sv | 21 ++
 rtl/tag_lookup_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_tag_lookup_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tag_lookup_ctrl_pkg.sv
// rtl/tag_lookup_ctrl_pkg.sv - shared types for the cache tag lookup controller
package tag_lookup_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_INV_CMP = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/tag_bank.sv
// rtl/tag_bank.sv - dual-port tag RAM, synchronous read, read data held when not enabled
module tag_bank #(
  parameter int WIDTH = 21,
  parameter int LINES = 64
) (
  input  logic                     clk,
  input  logic                     en_a,
  input  logic                     wen_a,
  input  logic [$clog2(LINES)-1:0] addr_a,
  input  logic [WIDTH-1:0]         wdata_a,
  output logic [WIDTH-1:0]         rdata_a,
  input  logic                     en_b,
  input  logic                     wen_b,
  input  logic [$clog2(LINES)-1:0] addr_b,
  input  logic [WIDTH-1:0]         wdata_b,
  output logic [WIDTH-1:0]         rdata_b
);

  logic [WIDTH-1:0] mem_q [LINES];

  // Both ports live in one process so the array has a single driver.
  always_ff @(posedge clk) begin
    if (en_a) begin
      if (wen_a) mem_q[addr_a] <= wdata_a;
      else       rdata_a       <= mem_q[addr_a];
    end
    if (en_b) begin
      if (wen_b) mem_q[addr_b] <= wdata_b;
      else       rdata_b       <= mem_q[addr_b];
    end
  end

endmodule

// File: rtl/tag_lookup_ctrl_compare.sv
// rtl/tag_lookup_ctrl_compare.sv - per-way {valid,tag} comparator with registered-write forwarding
module tag_way_compare #(
  parameter int WAYS  = 2,
  parameter int ENT_W = 21
) (
  input  logic [WAYS-1:0][ENT_W-1:0] rdata,
  input  logic [WAYS-1:0]            fwd_mask,
  input  logic [ENT_W-1:0]           fwd_data,
  input  logic [ENT_W-1:0]           key,
  output logic [WAYS-1:0]            match
);

  // Key always carries valid=1, so cleared (all-zero) entries never match.
  always_comb begin
    match = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = ((fwd_mask[w] ? fwd_data : rdata[w]) == key);
    end
  end

endmodule

// File: rtl/tag_lookup_ctrl.sv
// rtl/tag_lookup_ctrl.sv - set-associative tag store controller: clear sweep, lookups, fills, invalidates
module tag_lookup_ctrl
  import tag_lookup_ctrl_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int LINES = 64,
  parameter int TAG_W = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic                     lookup_valid,
  output logic                     lookup_ready,
  input  logic [$clog2(LINES)-1:0] lookup_line,
  input  logic [TAG_W-1:0]         lookup_tag,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [WAYS-1:0]          resp_way,
  input  logic                     fill_valid,
  output logic                     fill_ready,
  input  logic [$clog2(LINES)-1:0] fill_line,
  input  logic [WAYS-1:0]          fill_way,
  input  logic [TAG_W-1:0]         fill_tag,
  input  logic                     inv_valid,
  output logic                     inv_ready,
  input  logic [$clog2(LINES)-1:0] inv_line,
  input  logic [TAG_W-1:0]         inv_tag,
  output logic                     inv_done,
  output logic                     inv_hit
);

  localparam int LINE_W = $clog2(LINES);
  localparam int ENT_W  = TAG_W + 1;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } entry_t;

  ctrl_state_t       state_q, state_d;
  logic [LINE_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              resp_valid_q, resp_valid_d;
  logic [TAG_W-1:0]  lk_tag_q, lk_tag_d;
  logic [WAYS-1:0]   fwd_mask_q, fwd_mask_d;
  entry_t            fwd_data_q, fwd_data_d;
  logic [TAG_W-1:0]  inv_tag_q, inv_tag_d;
  logic [LINE_W-1:0] inv_line_q, inv_line_d;
  logic              inv_done_q, inv_done_d;
  logic              inv_hit_q, inv_hit_d;

  logic [WAYS-1:0][ENT_W-1:0] rdata_a, rdata_b;
  logic [LINE_W-1:0]          addr_b;
  entry_t                     wdata_b;
  logic [WAYS-1:0]            en_b, wen_b;
  logic [WAYS-1:0]            lk_match, inv_match;
  entry_t                     lk_key, inv_key;
  logic                       lookup_fire;
  logic                       fwd_hit;

  assign lookup_fire = lookup_valid & init_done_q;
  assign lk_key      = '{valid: 1'b1, tag: lk_tag_q};
  assign inv_key     = '{valid: 1'b1, tag: inv_tag_q};

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    tag_bank #(
      .WIDTH(ENT_W),
      .LINES(LINES)
    ) u_bank (
      .clk    (clk),
      .en_a   (lookup_fire),
      .wen_a  (1'b0),
      .addr_a (lookup_line),
      .wdata_a({ENT_W{1'b0}}),
      .rdata_a(rdata_a[w]),
      .en_b   (en_b[w]),
      .wen_b  (wen_b[w]),
      .addr_b (addr_b),
      .wdata_b(wdata_b),
      .rdata_b(rdata_b[w])
    );
  end

  tag_way_compare #(
    .WAYS (WAYS),
    .ENT_W(ENT_W)
  ) u_lk_cmp (
    .rdata   (rdata_a),
    .fwd_mask(fwd_mask_q),
    .fwd_data(fwd_data_q),
    .key     (lk_key),
    .match   (lk_match)
  );

  // Fills never coincide with an invalidate read, so this path needs no forwarding.
  tag_way_compare #(
    .WAYS (WAYS),
    .ENT_W(ENT_W)
  ) u_inv_cmp (
    .rdata   (rdata_b),
    .fwd_mask({WAYS{1'b0}}),
    .fwd_data({ENT_W{1'b0}}),
    .key     (inv_key),
    .match   (inv_match)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    inv_tag_d   = inv_tag_q;
    inv_line_d  = inv_line_q;
    inv_done_d  = 1'b0;
    inv_hit_d   = 1'b0;
    addr_b      = '0;
    wdata_b     = '0;
    en_b        = '0;
    wen_b       = '0;
    case (state_q)
      ST_INIT: begin
        addr_b = cnt_q;
        en_b   = '1;
        wen_b  = '1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_LINE) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (fill_valid) begin
          addr_b  = fill_line;
          wdata_b = '{valid: 1'b1, tag: fill_tag};
          en_b    = fill_way;
          wen_b   = fill_way;
        end else if (inv_valid) begin
          addr_b     = inv_line;
          en_b       = '1;
          inv_tag_d  = inv_tag;
          inv_line_d = inv_line;
          state_d    = ST_INV_CMP;
        end
      end
      ST_INV_CMP: begin
        addr_b     = inv_line_q;
        en_b       = inv_match;
        wen_b      = inv_match;
        inv_done_d = 1'b1;
        inv_hit_d  = |inv_match;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
    if (rst) begin
      en_b  = '0;
      wen_b = '0;
    end
  end

  // A port-B write to the line being looked up this cycle is replayed over the bank output next cycle.
  always_comb begin
    fwd_hit      = lookup_fire && (|wen_b) && (addr_b == lookup_line);
    fwd_mask_d   = fwd_hit ? wen_b : '0;
    fwd_data_d   = fwd_hit ? wdata_b : fwd_data_q;
    resp_valid_d = lookup_fire;
    lk_tag_d     = lookup_fire ? lookup_tag : lk_tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      init_done_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      lk_tag_q     <= '0;
      fwd_mask_q   <= '0;
      fwd_data_q   <= '0;
      inv_tag_q    <= '0;
      inv_line_q   <= '0;
      inv_done_q   <= 1'b0;
      inv_hit_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_done_q  <= init_done_d;
      resp_valid_q <= resp_valid_d;
      lk_tag_q     <= lk_tag_d;
      fwd_mask_q   <= fwd_mask_d;
      fwd_data_q   <= fwd_data_d;
      inv_tag_q    <= inv_tag_d;
      inv_line_q   <= inv_line_d;
      inv_done_q   <= inv_done_d;
      inv_hit_q    <= inv_hit_d;
    end
  end

  assign init_done    = init_done_q;
  assign lookup_ready = init_done_q;
  assign fill_ready   = (state_q == ST_IDLE);
  assign inv_ready    = (state_q == ST_IDLE) && !fill_valid;
  assign resp_valid   = resp_valid_q;
  assign resp_way     = resp_valid_q ? lk_match : '0;
  assign resp_hit     = |resp_way;
  assign inv_done     = inv_done_q;
  assign inv_hit      = inv_hit_q;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// tb/tb_tag_lookup_ctrl.sv - directed self-checking bench for tag_lookup_ctrl
module tb_tag_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        lookup_valid;
  logic        lookup_ready;
  logic [5:0]  lookup_line;
  logic [19:0] lookup_tag;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic        fill_valid;
  logic        fill_ready;
  logic [5:0]  fill_line;
  logic [1:0]  fill_way;
  logic [19:0] fill_tag;
  logic        inv_valid;
  logic        inv_ready;
  logic [5:0]  inv_line;
  logic [19:0] inv_tag;
  logic        inv_done;
  logic        inv_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tag_lookup_ctrl #(.WAYS(2), .LINES(64), .TAG_W(20)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_line(lookup_line), .lookup_tag(lookup_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_line(fill_line),
    .fill_way(fill_way), .fill_tag(fill_tag),
    .inv_valid(inv_valid), .inv_ready(inv_ready), .inv_line(inv_line),
    .inv_tag(inv_tag), .inv_done(inv_done), .inv_hit(inv_hit)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [5:0] line, input logic [19:0] tag);
    lookup_valid = 1'b1;
    lookup_line  = line;
    lookup_tag   = tag;
    step();
    lookup_valid = 1'b0;
  endtask

  task automatic fill(input logic [5:0] line, input logic [1:0] way, input logic [19:0] tag);
    fill_valid = 1'b1;
    fill_line  = line;
    fill_way   = way;
    fill_tag   = tag;
    step();
    fill_valid = 1'b0;
  endtask

  task automatic sweep_check(input string name);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (init_done !== 1'b0 || lookup_ready !== 1'b0 || fill_ready !== 1'b0 || inv_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: init_done=%b lookup_ready=%b fill_ready=%b inv_ready=%b required all 0",
                 name, i, init_done, lookup_ready, fill_ready, inv_ready);
      end
      step();
    end
    checks++;
    if (init_done !== 1'b1 || lookup_ready !== 1'b1 || fill_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s done: init_done=%b lookup_ready=%b fill_ready=%b required 1 1 1",
               name, init_done, lookup_ready, fill_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lookup_valid = 0; lookup_line = 0; lookup_tag = 0;
    fill_valid = 0; fill_line = 0; fill_way = 0; fill_tag = 0;
    inv_valid = 0; inv_line = 0; inv_tag = 0;
    repeat (3) step();
    checks++;
    if (init_done !== 1'b0 || resp_valid !== 1'b0 || resp_way !== 2'b00 || resp_hit !== 1'b0 ||
        inv_done !== 1'b0 || inv_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: init_done=%b resp_valid=%b resp_way=%b resp_hit=%b inv_done=%b inv_hit=%b required all 0",
               init_done, resp_valid, resp_way, resp_hit, inv_done, inv_hit);
    end
    rst = 1'b0;
    sweep_check("reset_sweep");
    lookup(6'd5, 20'h00000);
    checks++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || resp_way !== 2'b00) begin
      errors++;
      $display("FAIL post_init_lookup: valid=%b hit=%b way=%b required 1 0 00", resp_valid, resp_hit, resp_way);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL resp_valid_idle: resp_valid=%b required 0", resp_valid);
    end
  endtask

  task automatic test_fill_lookup();
    fill(6'd7, 2'b01, 20'hABCDE);
    lookup(6'd7, 20'hABCDE);
    checks++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_way !== 2'b01) begin
      errors++;
      $display("FAIL fill_lookup_hit: valid=%b hit=%b way=%b required 1 1 01", resp_valid, resp_hit, resp_way);
    end
    lookup(6'd7, 20'hABCDF);
    checks++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || resp_way !== 2'b00) begin
      errors++;
      $display("FAIL fill_lookup_miss: valid=%b hit=%b way=%b required 1 0 00", resp_valid, resp_hit, resp_way);
    end
  endtask

  task automatic test_forwarding();
    fill_valid = 1'b1; fill_line = 6'd3; fill_way = 2'b10; fill_tag = 20'h12345;
    lookup(6'd3, 20'h12345);
    fill_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_way !== 2'b10) begin
      errors++;
      $display("FAIL fwd_same_cycle: valid=%b hit=%b way=%b required 1 1 10", resp_valid, resp_hit, resp_way);
    end
    fill_valid = 1'b1; fill_line = 6'd3; fill_way = 2'b01; fill_tag = 20'h12345;
    #1;
    checks++;
    if (resp_way !== 2'b10) begin
      errors++;
      $display("FAIL fwd_late_write: resp_way=%b required 10", resp_way);
    end
    step();
    fill_valid = 1'b0;
    lookup(6'd3, 20'h12345);
    checks++;
    if (resp_hit !== 1'b1 || resp_way !== 2'b11) begin
      errors++;
      $display("FAIL multi_hit: hit=%b way=%b required 1 11", resp_hit, resp_way);
    end
  endtask

  task automatic test_invalidate();
    fill(6'd9, 2'b10, 20'h55555);
    inv_valid = 1'b1; inv_line = 6'd9; inv_tag = 20'h55554;
    #1;
    checks++;
    if (inv_ready !== 1'b1) begin
      errors++;
      $display("FAIL inv_ready_idle: inv_ready=%b required 1", inv_ready);
    end
    step();
    inv_valid = 1'b0;
    checks++;
    if (fill_ready !== 1'b0 || inv_ready !== 1'b0 || inv_done !== 1'b0) begin
      errors++;
      $display("FAIL inv_cmp_state: fill_ready=%b inv_ready=%b inv_done=%b required 0 0 0", fill_ready, inv_ready, inv_done);
    end
    step();
    checks++;
    if (inv_done !== 1'b1 || inv_hit !== 1'b0) begin
      errors++;
      $display("FAIL inv_wrong_tag: inv_done=%b inv_hit=%b required 1 0", inv_done, inv_hit);
    end
    lookup(6'd9, 20'h55555);
    checks++;
    if (resp_hit !== 1'b1 || resp_way !== 2'b10 || inv_done !== 1'b0) begin
      errors++;
      $display("FAIL inv_wrong_tag_keep: hit=%b way=%b inv_done=%b required 1 10 0", resp_hit, resp_way, inv_done);
    end
    inv_valid = 1'b1; inv_line = 6'd9; inv_tag = 20'h55555;
    step();
    inv_valid = 1'b0;
    step();
    checks++;
    if (inv_done !== 1'b1 || inv_hit !== 1'b1) begin
      errors++;
      $display("FAIL inv_match: inv_done=%b inv_hit=%b required 1 1", inv_done, inv_hit);
    end
    step();
    checks++;
    if (inv_done !== 1'b0) begin
      errors++;
      $display("FAIL inv_done_pulse: inv_done=%b required 0", inv_done);
    end
    lookup(6'd9, 20'h55555);
    checks++;
    if (resp_hit !== 1'b0 || resp_way !== 2'b00) begin
      errors++;
      $display("FAIL inv_cleared: hit=%b way=%b required 0 00", resp_hit, resp_way);
    end
  endtask

  task automatic test_arbitration();
    fill_valid = 1'b1; fill_line = 6'd12; fill_way = 2'b01; fill_tag = 20'h0F0F0;
    inv_valid = 1'b1; inv_line = 6'd12; inv_tag = 20'h0F0F0;
    #1;
    checks++;
    if (fill_ready !== 1'b1 || inv_ready !== 1'b0) begin
      errors++;
      $display("FAIL arb_priority: fill_ready=%b inv_ready=%b required 1 0", fill_ready, inv_ready);
    end
    step();
    fill_valid = 1'b0;
    #1;
    checks++;
    if (inv_ready !== 1'b1) begin
      errors++;
      $display("FAIL arb_inv_next: inv_ready=%b required 1", inv_ready);
    end
    step();
    inv_valid = 1'b0;
    checks++;
    if (fill_ready !== 1'b0) begin
      errors++;
      $display("FAIL arb_fill_ready_cmp: fill_ready=%b required 0", fill_ready);
    end
    step();
    checks++;
    if (inv_done !== 1'b1 || inv_hit !== 1'b1) begin
      errors++;
      $display("FAIL arb_fill_then_inv: inv_done=%b inv_hit=%b required 1 1", inv_done, inv_hit);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  lines [3];
    logic [19:0] tags  [3];
    logic [1:0]  exp   [3];
    lines = '{6'd40, 6'd40, 6'd41};
    tags  = '{20'h00001, 20'h00002, 20'h00001};
    exp   = '{2'b10, 2'b00, 2'b00};
    fill(6'd40, 2'b10, 20'h00001);
    lookup_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lookup_line = lines[i];
      lookup_tag  = tags[i];
      step();
      checks++;
      if (resp_valid !== 1'b1 || resp_way !== exp[i] || resp_hit !== (|exp[i])) begin
        errors++;
        $display("FAIL back_to_back[%0d]: valid=%b way=%b hit=%b required 1 %b %b",
                 i, resp_valid, resp_way, resp_hit, exp[i], |exp[i]);
      end
    end
    lookup_valid = 1'b0;
  endtask

  task automatic test_reset_midop();
    fill(6'd20, 2'b01, 20'h13579);
    inv_valid = 1'b1; inv_line = 6'd20; inv_tag = 20'h13579;
    step();
    inv_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (inv_done !== 1'b0 || inv_hit !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_inv_cmp: inv_done=%b inv_hit=%b init_done=%b required 0 0 0", inv_done, inv_hit, init_done);
    end
    step();
    rst = 1'b0;
    repeat (30) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep_check("resweep");
    lookup(6'd20, 20'h13579);
    checks++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_20: valid=%b hit=%b required 1 0", resp_valid, resp_hit);
    end
    lookup(6'd7, 20'hABCDE);
    checks++;
    if (resp_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_7: hit=%b required 0", resp_hit);
    end
    lookup(6'd3, 20'h12345);
    checks++;
    if (resp_hit !== 1'b0 || resp_way !== 2'b00) begin
      errors++;
      $display("FAIL reset_clears_3: hit=%b way=%b required 0 00", resp_hit, resp_way);
    end
  endtask

  initial begin
    test_reset();
    test_fill_lookup();
    test_forwarding();
    test_invalidate();
    test_arbitration();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
